mem_ctrl: RTL
=============

Name: mem_ctrl

Overview:
- Byte-serial memory controller between the store/load buffer and the unified RAM, and between the instruction fetcher and the same RAM.
- Accepts word instruction fetches and 1/2/4-byte loads and stores, and serialises them onto an 8-bit RAM port.
- Returns the assembled and extended load data tagged with its ROB index for common-data-bus broadcast.

Parameters:
ADDR_W, 32, byte address width
ROB_W, 4, ROB index width (matches the ROB index type)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
rdy  in  1  global ready; when low, no new request is accepted
rb  in  1  rollback: abort the in-flight load or fetch
if_ena  in  1  fetch request, held high until if_done
if_addr  in  ADDR_W  fetch address
if_done  out  1  one-cycle pulse, if_inst valid
if_inst  out  32  fetched word, little-endian
ld_ena  in  1  load request, held high until ld_done
ld_addr  in  ADDR_W  load address
ld_len  in  4  bytes minus 1 (0, 1 or 3)
ld_sext  in  1  sign-extend the result
ld_src  in  ROB_W  ROB tag of the load
ld_done  out  1  one-cycle pulse
ld_data  out  32  extended load result
ld_tag  out  ROB_W  tag captured at acceptance
st_ena  in  1  store request, held high until st_done
st_addr  in  ADDR_W  store address
st_len  in  4  bytes minus 1 (0, 1 or 3)
st_data  in  32  store data; low bytes are used
st_done  out  1  one-cycle pulse
mem_din  in  8  RAM read data
mem_dout  out  8  RAM write data
mem_a  out  ADDR_W  RAM address
mem_wr  out  1  1 = write
io_buffer_full  in  1  UART buffer full

Behaviour:
- Reset (rst low, asynchronous): state IDLE; all outputs 0 (if_done, if_inst, ld_done, ld_data, ld_tag, st_done, mem_dout, mem_a, mem_wr).
- States: IDLE, FETCH, LOAD, STORE. Byte counter cnt is 3 bits wide; the captured length N is len+1.
- Accept in IDLE only, and only when rdy is high. Fixed priority: st_ena > ld_ena > if_ena.
- No acceptance in a cycle where any done output is high. Requesters drop ena one cycle after seeing done, so this prevents re-issuing the same request.
- A store with st_addr[17:16]==2'b11 (I/O space) is not accepted while io_buffer_full is high. It stays pending; lower-priority requests also wait.
- Address and length are captured at the acceptance edge E0. mem_a is registered and carries addr+k at edge Ek; addresses are modulo 2^ADDR_W.
- RAM read latency:
  - The byte for the address driven at Ek is sampled from mem_din at edge Ek+2.
  - Byte k is placed at bits [8k+7:8k].
- LOAD/FETCH completion:
  - The last byte is sampled at E(N+1).
  - At that same edge: done=1, state returns to IDLE, and mem_a returns to 0.
  - Latency: word = 5 cycles, half = 3, byte = 2.
- Load extension:
  - len 0: sign- or zero-extend bit 7 per ld_sext.
  - len 1: extend bit 15 per ld_sext.
  - len 3: no extension.
- ld_tag is set to the captured ld_src at the same edge as ld_done.
- STORE:
  - At Ek (k = 0..N-1): mem_wr=1, mem_a=addr+k, mem_dout=st_data[8k+7:8k].
  - At EN: mem_wr=0, st_done=1, state IDLE.
- mem_wr is 1 only during STORE byte cycles.
- Done pulses last exactly one cycle. if_inst and ld_data hold their last value afterwards.
- Rollback (rb high at an edge):
  - In FETCH or LOAD: go to IDLE with no done pulse; in-flight RAM reads are discarded.
  - In IDLE: no request is accepted that cycle.
  - In STORE: the store runs to completion and st_done still pulses, because stores are committed.
- rdy low mid-transaction: the transaction continues; rdy gates acceptance only.
- Reset asserted mid-transaction: immediate return to reset values; a partial store is abandoned.

Test Plan:
- Fetch: if_ena=1, if_addr=0x100, RAM[0x100..0x103]=13,05,00,00 -> if_done at cycle 5 after acceptance, if_inst=0x00000513. mem_a sequence is 0x100..0x103.
- Load sign extension: LB from 0x20 holding 0x80, ld_sext=1, ld_src=7 -> ld_done at cycle 2, ld_data=0xFFFFFF80, ld_tag=7. LHU of 0x80F0 -> 0x000080F0.
- Priority: st_ena, ld_ena and if_ena all raised together; SW 0xDEADBEEF to 0x40 -> mem_wr=1 for 4 cycles writing EF,BE,AD,DE, then st_done. The load starts only after st_done drops and finishes before the fetch.
- Rollback: LW accepted, rb pulsed at cycle 2 -> no ld_done, IDLE next cycle. Repeat with rb during an SB -> the write completes and st_done pulses.
- I/O: SB to 0x30000 with io_buffer_full=1 for 3 cycles -> mem_wr stays 0. It is accepted the cycle after io_buffer_full falls, and writes 1 byte.
- Async reset mid-LW: rst low between edges -> outputs go to 0 immediately with no done pulse. After release, a new fetch completes normally.

Source files
------------

// File: rtl/mem_ctrl_if.sv
// Signal bundle shared by mem_ctrl, its requesters (fetcher, load/store buffer) and the byte-wide RAM.
// The master modport is the environment side; the slave modport is the controller.
interface mem_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int ROB_W  = 4
);
  logic              rdy;
  logic              rb;

  logic              if_ena;
  logic [ADDR_W-1:0] if_addr;
  logic              if_done;
  logic [31:0]       if_inst;

  logic              ld_ena;
  logic [ADDR_W-1:0] ld_addr;
  logic [3:0]        ld_len;
  logic              ld_sext;
  logic [ROB_W-1:0]  ld_src;
  logic              ld_done;
  logic [31:0]       ld_data;
  logic [ROB_W-1:0]  ld_tag;

  logic              st_ena;
  logic [ADDR_W-1:0] st_addr;
  logic [3:0]        st_len;
  logic [31:0]       st_data;
  logic              st_done;

  logic [7:0]        mem_din;
  logic [7:0]        mem_dout;
  logic [ADDR_W-1:0] mem_a;
  logic              mem_wr;
  logic              io_buffer_full;

  modport master (
    output rdy, rb,
    output if_ena, if_addr,
    input  if_done, if_inst,
    output ld_ena, ld_addr, ld_len, ld_sext, ld_src,
    input  ld_done, ld_data, ld_tag,
    output st_ena, st_addr, st_len, st_data,
    input  st_done,
    output mem_din, io_buffer_full,
    input  mem_dout, mem_a, mem_wr
  );

  modport slave (
    input  rdy, rb,
    input  if_ena, if_addr,
    output if_done, if_inst,
    input  ld_ena, ld_addr, ld_len, ld_sext, ld_src,
    output ld_done, ld_data, ld_tag,
    input  st_ena, st_addr, st_len, st_data,
    output st_done,
    input  mem_din, io_buffer_full,
    output mem_dout, mem_a, mem_wr
  );
endinterface

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: serialises word fetches and 1/2/4-byte loads/stores onto an
// 8-bit RAM port with a two-cycle read latency, returning extended load data tagged with its ROB index.
module mem_ctrl #(
  parameter int ADDR_W = 32,
  parameter int ROB_W  = 4
) (
  input  logic     clk,
  input  logic     rst,
  mem_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_STORE
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [2:0]        num_q, num_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              sext_q, sext_d;
  logic [ROB_W-1:0]  src_q, src_d;
  logic [31:0]       sdata_q, sdata_d;
  logic [31:0]       asm_q, asm_d;

  logic [ADDR_W-1:0] mem_a_q, mem_a_d;
  logic [7:0]        mem_dout_q, mem_dout_d;
  logic              mem_wr_q, mem_wr_d;
  logic              if_done_q, if_done_d;
  logic [31:0]       if_inst_q, if_inst_d;
  logic              ld_done_q, ld_done_d;
  logic [31:0]       ld_data_q, ld_data_d;
  logic [ROB_W-1:0]  ld_tag_q, ld_tag_d;
  logic              st_done_q, st_done_d;

  logic [2:0]        edge_idx;
  logic [1:0]        bidx;
  logic              any_done;
  logic              io_block;

  function automatic logic [31:0] extend(input logic [31:0] raw, input logic [2:0] n,
                                         input logic sx);
    logic [31:0] res;
    res = raw;
    if (n == 3'd1) begin
      res = {{24{sx & raw[7]}}, raw[7:0]};
    end else if (n == 3'd2) begin
      res = {{16{sx & raw[15]}}, raw[15:0]};
    end
    return res;
  endfunction

  // edge_idx is k for the edge Ek being evaluated; read byte k-2 arrives on mem_din at Ek.
  assign edge_idx = cnt_q + 3'd1;
  assign bidx     = 2'(cnt_q - 3'd1);
  assign any_done = if_done_q | ld_done_q | st_done_q;
  assign io_block = bus.st_ena && (bus.st_addr[17:16] == 2'b11) && bus.io_buffer_full;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    num_d      = num_q;
    addr_d     = addr_q;
    sext_d     = sext_q;
    src_d      = src_q;
    sdata_d    = sdata_q;
    asm_d      = asm_q;
    mem_a_d    = mem_a_q;
    mem_dout_d = mem_dout_q;
    mem_wr_d   = mem_wr_q;
    if_done_d  = 1'b0;
    if_inst_d  = if_inst_q;
    ld_done_d  = 1'b0;
    ld_data_d  = ld_data_q;
    ld_tag_d   = ld_tag_q;
    st_done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.rdy && !bus.rb && !any_done) begin
          if (bus.st_ena) begin
            // A blocked I/O store holds off every lower-priority request too.
            if (!io_block) begin
              state_d    = S_STORE;
              cnt_d      = 3'd0;
              num_d      = 3'(bus.st_len + 4'd1);
              addr_d     = bus.st_addr;
              sdata_d    = bus.st_data;
              mem_a_d    = bus.st_addr;
              mem_dout_d = bus.st_data[7:0];
              mem_wr_d   = 1'b1;
            end
          end else if (bus.ld_ena) begin
            state_d = S_LOAD;
            cnt_d   = 3'd0;
            num_d   = 3'(bus.ld_len + 4'd1);
            addr_d  = bus.ld_addr;
            sext_d  = bus.ld_sext;
            src_d   = bus.ld_src;
            asm_d   = 32'd0;
            mem_a_d = bus.ld_addr;
          end else if (bus.if_ena) begin
            state_d = S_FETCH;
            cnt_d   = 3'd0;
            num_d   = 3'd4;
            addr_d  = bus.if_addr;
            asm_d   = 32'd0;
            mem_a_d = bus.if_addr;
          end
        end
      end

      S_FETCH, S_LOAD: begin
        if (bus.rb) begin
          state_d = S_IDLE;
          cnt_d   = 3'd0;
          mem_a_d = '0;
        end else begin
          cnt_d = edge_idx;
          if (edge_idx < num_q) begin
            mem_a_d = addr_q + ADDR_W'(edge_idx);
          end
          if (edge_idx >= 3'd2) begin
            for (int b = 0; b < 4; b++) begin
              if (bidx == 2'(b)) begin
                asm_d[8*b +: 8] = bus.mem_din;
              end
            end
          end
          if (edge_idx == num_q + 3'd1) begin
            state_d = S_IDLE;
            cnt_d   = 3'd0;
            mem_a_d = '0;
            if (state_q == S_FETCH) begin
              if_done_d = 1'b1;
              if_inst_d = asm_d;
            end else begin
              ld_done_d = 1'b1;
              ld_data_d = extend(asm_d, num_q, sext_q);
              ld_tag_d  = src_q;
            end
          end
        end
      end

      S_STORE: begin
        // Stores are already committed, so rollback does not interrupt them.
        cnt_d = edge_idx;
        if (edge_idx < num_q) begin
          mem_a_d    = addr_q + ADDR_W'(edge_idx);
          mem_dout_d = sdata_q[8*edge_idx[1:0] +: 8];
          mem_wr_d   = 1'b1;
        end else begin
          state_d    = S_IDLE;
          cnt_d      = 3'd0;
          mem_a_d    = '0;
          mem_dout_d = 8'd0;
          mem_wr_d   = 1'b0;
          st_done_d  = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= 3'd0;
      num_q      <= 3'd0;
      addr_q     <= '0;
      sext_q     <= 1'b0;
      src_q      <= '0;
      sdata_q    <= 32'd0;
      asm_q      <= 32'd0;
      mem_a_q    <= '0;
      mem_dout_q <= 8'd0;
      mem_wr_q   <= 1'b0;
      if_done_q  <= 1'b0;
      if_inst_q  <= 32'd0;
      ld_done_q  <= 1'b0;
      ld_data_q  <= 32'd0;
      ld_tag_q   <= '0;
      st_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      num_q      <= num_d;
      addr_q     <= addr_d;
      sext_q     <= sext_d;
      src_q      <= src_d;
      sdata_q    <= sdata_d;
      asm_q      <= asm_d;
      mem_a_q    <= mem_a_d;
      mem_dout_q <= mem_dout_d;
      mem_wr_q   <= mem_wr_d;
      if_done_q  <= if_done_d;
      if_inst_q  <= if_inst_d;
      ld_done_q  <= ld_done_d;
      ld_data_q  <= ld_data_d;
      ld_tag_q   <= ld_tag_d;
      st_done_q  <= st_done_d;
    end
  end

  assign bus.if_done  = if_done_q;
  assign bus.if_inst  = if_inst_q;
  assign bus.ld_done  = ld_done_q;
  assign bus.ld_data  = ld_data_q;
  assign bus.ld_tag   = ld_tag_q;
  assign bus.st_done  = st_done_q;
  assign bus.mem_dout = mem_dout_q;
  assign bus.mem_a    = mem_a_q;
  assign bus.mem_wr   = mem_wr_q;

endmodule
